bird_physics_fsm: RTL and testbench

Parametrised successor to the single-bird game block. It owns the bird's vertical physics, the game state machine and score/high-score bookkeeping, advancing once per frame `tick`. It uses signed velocity with gravity, flap impulse, terminal velocity, ceiling/floor bounds, pause, death hold-off and pipe pass/hit events. It sits between the input conditioner and the renderer/pipe generator.

---
 rtl/game_pkg.sv | 26 ++
 rtl/bird_integrator.sv | 63 ++++++
 rtl/bird_physics_fsm.sv | 158 +++++++++++++++
 tb/tb_bird_physics_fsm.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the bird game: state encoding, default physics constants
// and the score width used by the single- and multi-bird variants.
package game_pkg;

  localparam int SCORE_W = 10;

  localparam int DEF_Y_W        = 9;
  localparam int DEF_V_W        = 8;
  localparam int DEF_BIRD_X     = 140;
  localparam int DEF_Y_START    = 240;
  localparam int DEF_Y_MIN      = 0;
  localparam int DEF_Y_MAX      = 479;
  localparam int DEF_BIRD_H     = 16;
  localparam int DEF_FLAP_V     = 10;
  localparam int DEF_GRAVITY    = 1;
  localparam int DEF_MAX_FALL   = 12;
  localparam int DEF_DEAD_TICKS = 50;

  typedef logic [1:0] game_state_t;

  localparam game_state_t ST_IDLE    = 2'd0;
  localparam game_state_t ST_PLAYING = 2'd1;
  localparam game_state_t ST_PAUSED  = 2'd2;
  localparam game_state_t ST_DEAD    = 2'd3;

endpackage

// File: rtl/bird_integrator.sv
// One physics step for a bird: flap/gravity velocity update with terminal
// velocity, then position integration clamped to the ceiling and floor.
import game_pkg::*;

module bird_integrator #(
  parameter int Y_W      = DEF_Y_W,
  parameter int V_W      = DEF_V_W,
  parameter int Y_MIN    = DEF_Y_MIN,
  parameter int Y_MAX    = DEF_Y_MAX,
  parameter int BIRD_H   = DEF_BIRD_H,
  parameter int FLAP_V   = DEF_FLAP_V,
  parameter int GRAVITY  = DEF_GRAVITY,
  parameter int MAX_FALL = DEF_MAX_FALL
) (
  input  logic signed [V_W-1:0] velocity_i,
  input  logic        [Y_W-1:0] bird_y_i,
  input  logic                  flap_i,
  output logic signed [V_W-1:0] v_new_o,
  output logic        [Y_W-1:0] y_new_o,
  output logic                  hit_floor_o,
  output logic                  hit_ceiling_o
);

  localparam int YS_W = ((Y_W > V_W) ? Y_W : V_W) + 2;

  localparam logic signed [V_W:0]    MAX_V    = (V_W+1)'(MAX_FALL);
  localparam logic signed [V_W:0]    FLAP_VEL = (V_W+1)'(-FLAP_V);
  localparam logic signed [V_W:0]    GRAV_V   = (V_W+1)'(GRAVITY);
  localparam logic signed [YS_W-1:0] FLOOR_Y  = YS_W'(Y_MAX - BIRD_H);
  localparam logic signed [YS_W-1:0] CEIL_Y   = YS_W'(Y_MIN);

  logic signed [V_W:0]    v_grav;
  logic signed [V_W:0]    v_sel;
  logic signed [YS_W-1:0] y_sum;

  // Velocity is widened by one bit so gravity cannot wrap before saturation.
  always_comb begin
    v_grav = $signed({velocity_i[V_W-1], velocity_i}) + GRAV_V;
    if (flap_i) begin
      v_sel = FLAP_VEL;
    end else if (v_grav > MAX_V) begin
      v_sel = MAX_V;
    end else begin
      v_sel = v_grav;
    end

    y_sum = $signed({{(YS_W-Y_W){1'b0}}, bird_y_i})
          + $signed({{(YS_W-V_W-1){v_sel[V_W]}}, v_sel});

    hit_floor_o   = (y_sum >= FLOOR_Y);
    hit_ceiling_o = !hit_floor_o && (y_sum <= CEIL_Y);
    v_new_o       = v_sel[V_W-1:0];

    if (hit_floor_o) begin
      y_new_o = FLOOR_Y[Y_W-1:0];
    end else if (hit_ceiling_o) begin
      y_new_o = CEIL_Y[Y_W-1:0];
    end else begin
      y_new_o = y_sum[Y_W-1:0];
    end
  end

endmodule

// File: rtl/bird_physics_fsm.sv
// Single-bird game core: state machine, per-tick physics, score and high score.
// Define FLAP_EDGE_EN to make a flap event the rising edge of flap instead of its level.
import game_pkg::*;

module bird_physics_fsm #(
  parameter int Y_W        = DEF_Y_W,
  parameter int V_W        = DEF_V_W,
  parameter int SCORE_W    = game_pkg::SCORE_W,
  parameter int BIRD_X     = DEF_BIRD_X,
  parameter int Y_START    = DEF_Y_START,
  parameter int Y_MIN      = DEF_Y_MIN,
  parameter int Y_MAX      = DEF_Y_MAX,
  parameter int BIRD_H     = DEF_BIRD_H,
  parameter int FLAP_V     = DEF_FLAP_V,
  parameter int GRAVITY    = DEF_GRAVITY,
  parameter int MAX_FALL   = DEF_MAX_FALL,
  parameter int DEAD_TICKS = DEF_DEAD_TICKS
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      flap,
  input  logic                      pause,
  input  logic                      pass_pipe,
  input  logic                      hit_pipe,
  output logic [1:0]                game_state,
  output logic [7:0]                bird_x,
  output logic [Y_W-1:0]            bird_y,
  output logic signed [V_W-1:0]     velocity,
  output logic [SCORE_W-1:0]        current_score,
  output logic [SCORE_W-1:0]        highest_score
);

  localparam int DC_W = $clog2(DEAD_TICKS + 1);
  localparam logic [DC_W-1:0] DEAD_MAX  = DC_W'(DEAD_TICKS);
  localparam logic [Y_W-1:0]  Y_SPAWN   = Y_W'(Y_START);
  localparam logic [SCORE_W-1:0] ONE_PT = SCORE_W'(1);

  game_state_t         state_q, state_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic signed [V_W-1:0] v_q, v_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [SCORE_W-1:0]  high_q, high_d;
  logic                pend_q, pend_d;
  logic [DC_W-1:0]     dcnt_q, dcnt_d;
  logic                flap_ev;

  logic signed [V_W-1:0] v_new;
  logic [Y_W-1:0]        y_new;
  logic                  hit_floor, hit_ceiling;

`ifdef FLAP_EDGE_EN
  logic flap_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) flap_q <= 1'b0;
    else       flap_q <= flap;
  end
  assign flap_ev = flap & ~flap_q;
`else
  assign flap_ev = flap;
`endif

  // A flap arriving on the same clock as the tick is applied on that tick.
  bird_integrator #(
    .Y_W(Y_W), .V_W(V_W), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .BIRD_H(BIRD_H),
    .FLAP_V(FLAP_V), .GRAVITY(GRAVITY), .MAX_FALL(MAX_FALL)
  ) u_integrator (
    .velocity_i    (v_q),
    .bird_y_i      (y_q),
    .flap_i        (pend_q | flap_ev),
    .v_new_o       (v_new),
    .y_new_o       (y_new),
    .hit_floor_o   (hit_floor),
    .hit_ceiling_o (hit_ceiling)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    v_d     = v_q;
    score_d = score_q;
    high_d  = high_q;
    pend_d  = pend_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        y_d = Y_SPAWN;
        v_d = '0;
        if (flap_ev) begin
          state_d = ST_PLAYING;
          score_d = '0;
          pend_d  = 1'b1;
        end
      end
      ST_PLAYING: begin
        if (flap_ev) pend_d = 1'b1;
        if (tick) begin
          y_d    = y_new;
          v_d    = (hit_floor || hit_ceiling) ? '0 : v_new;
          pend_d = 1'b0;
        end
        // A death on this clock swallows any simultaneous pass or pause.
        if (hit_pipe || (tick && hit_floor)) begin
          state_d = ST_DEAD;
          dcnt_d  = '0;
        end else begin
          if (pass_pipe && (score_q != '1)) score_d = score_q + ONE_PT;
          if (pause) state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (!pause) state_d = ST_PLAYING;
      end
      ST_DEAD: begin
        if (tick && (dcnt_q != DEAD_MAX)) dcnt_d = dcnt_q + 1'b1;
        if (flap_ev && (dcnt_q == DEAD_MAX)) begin
          state_d = ST_IDLE;
          y_d     = Y_SPAWN;
          v_d     = '0;
          pend_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q == ST_PLAYING) && (state_d == ST_DEAD) && (score_d > high_q)) begin
      high_d = score_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      y_q     <= Y_SPAWN;
      v_q     <= '0;
      score_q <= '0;
      high_q  <= '0;
      pend_q  <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      v_q     <= v_d;
      score_q <= score_d;
      high_q  <= high_d;
      pend_q  <= pend_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign game_state    = state_q;
  assign bird_x        = 8'(BIRD_X);
  assign bird_y        = y_q;
  assign velocity      = v_q;
  assign current_score = score_q;
  assign highest_score = high_q;

endmodule

// File: tb/tb_bird_physics_fsm.sv
// Directed bench for bird_physics_fsm with hand-computed trajectories and scores.
// Hold-flap expectations follow FLAP_EDGE_EN when it is defined.
module tb_bird_physics_fsm;

  logic        clock = 1'b0;
  logic        reset;
  logic        tick, flap, pause, pass_pipe, hit_pipe;
  logic [1:0]  game_state;
  logic [7:0]  bird_x;
  logic [8:0]  bird_y;
  logic signed [7:0] velocity;
  logic [9:0]  current_score, highest_score;

  int total = 0;
  int bad   = 0;

  bird_physics_fsm dut (
    .clock         (clock),
    .reset         (reset),
    .tick          (tick),
    .flap          (flap),
    .pause         (pause),
    .pass_pipe     (pass_pipe),
    .hit_pipe      (hit_pipe),
    .game_state    (game_state),
    .bird_x        (bird_x),
    .bird_y        (bird_y),
    .velocity      (velocity),
    .current_score (current_score),
    .highest_score (highest_score)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // checking
  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input int st, input int y, input int v);
    chk({tag, ".state"}, 32'(game_state), st);
    chk({tag, ".y"}, 32'(bird_y), y);
    chk({tag, ".v"}, 32'($signed(velocity)), v);
  endtask

  // drivers: inputs last one clock, outputs sampled 1 time unit after the edge
  task automatic cyc(input logic t, input logic f, input logic p,
                     input logic ps, input logic h);
    tick = t; flap = f; pause = p; pass_pipe = ps; hit_pipe = h;
    @(posedge clock);
    #1;
    tick = 0; flap = 0; pause = 0; pass_pipe = 0; hit_pipe = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1, 0, 0, 0, 0);
  endtask

  task automatic pulse_flap();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    tick = 0; flap = 0; pause = 0; pass_pipe = 0; hit_pipe = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // reset state
    chk_pos("rst", 0, 240, 0);
    chk("rst.cur", 32'(current_score), 0);
    chk("rst.hi", 32'(highest_score), 0);
    chk("rst.x", 32'(bird_x), 140);

    // start a run, first three ticks after the flap
    pulse_flap();
    chk("start.state", 32'(game_state), 1);
    ticks(1); chk_pos("flap1", 1, 230, -10);
    ticks(1); chk_pos("flap2", 1, 221, -9);
    ticks(1); chk_pos("flap3", 1, 213, -8);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("pass2.cur", 32'(current_score), 2);
    ticks(2); chk_pos("y200", 1, 200, -6);

    // reset mid-run
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0);
    chk_pos("midrst", 0, 240, 0);
    chk("midrst.cur", 32'(current_score), 0);
    chk("midrst.hi", 32'(highest_score), 0);

    // free fall to terminal velocity, then floor clamp
    pulse_flap();
    ticks(11); chk_pos("apex", 1, 185, 0);
    ticks(12); chk_pos("vmax", 1, 263, 12);
    ticks(1);  chk_pos("vsat", 1, 275, 12);
    ticks(15); chk_pos("prefloor", 1, 455, 12);
    ticks(1);  chk_pos("floor", 3, 463, 0);
    chk("floor.hi", 32'(highest_score), 0);

    // death hold-off
    ticks(10); pulse_flap();
    chk("dead10.state", 32'(game_state), 3);
    ticks(39); pulse_flap();
    chk("dead49.state", 32'(game_state), 3);
    ticks(4); pulse_flap();
    chk_pos("revive", 0, 240, 0);

    // score and high score
    pulse_flap();
    chk("run2.cur0", 32'(current_score), 0);
    repeat (5) cyc(0, 0, 0, 1, 0);
    chk("run2.cur5", 32'(current_score), 5);
    cyc(0, 0, 0, 1, 1);
    chk("passhit.state", 32'(game_state), 3);
    chk("passhit.cur", 32'(current_score), 5);
    chk("passhit.hi", 32'(highest_score), 5);
    ticks(50); pulse_flap();
    chk("idle.cur_kept", 32'(current_score), 5);
    pulse_flap();
    chk("run3.cur0", 32'(current_score), 0);
    repeat (3) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1);
    chk("run3.state", 32'(game_state), 3);
    chk("run3.cur", 32'(current_score), 3);
    chk("run3.hi", 32'(highest_score), 5);

    // pause freezes play; pass with pause still scores
    ticks(50); pulse_flap(); pulse_flap();
    ticks(3); chk_pos("prepause", 1, 213, -8);
    cyc(0, 0, 1, 1, 0);
    chk("pause.state", 32'(game_state), 2);
    chk("pause.cur", 32'(current_score), 1);
    repeat (10) cyc(1, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    chk_pos("paused", 2, 213, -8);
    cyc(0, 0, 0, 0, 0);
    chk("unpause.state", 32'(game_state), 1);
    ticks(1); chk_pos("resume", 1, 206, -7);

    // holding flap across five ticks
    repeat (5) begin
      cyc(0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
    end
`ifdef FLAP_EDGE_EN
    chk_pos("hold", 1, 166, -6);
`else
    chk_pos("hold", 1, 156, -10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
